// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter. Buffers results from several functional
//               units in per-source FIFOs and grants one per cycle round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int NR_SRC        = 3,
    parameter int DEPTH         = 4,
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic [NR_SRC-1:0]               src_valid_i,
    input  logic [NR_SRC*TRANS_ID_BITS-1:0] src_trans_id_i,
    input  logic [NR_SRC*XLEN-1:0]          src_result_i,
    input  logic [NR_SRC-1:0]               src_ex_valid_i,
    input  logic [NR_SRC*XLEN-1:0]          src_ex_cause_i,
    input  logic [NR_SRC*XLEN-1:0]          src_ex_tval_i,
    output logic                            src_stall_o,
    output logic                            wb_valid_o,
    input  logic                            wb_ready_i,
    output logic [1:0]                      wb_src_o,
    output logic [TRANS_ID_BITS-1:0]        wb_trans_id_o,
    output logic [XLEN-1:0]                 wb_result_o,
    output logic                            wb_ex_valid_o,
    output logic [XLEN-1:0]                 wb_ex_cause_o,
    output logic [XLEN-1:0]                 wb_ex_tval_o,
    output logic                            overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

    logic [NR_SRC-1:0]               not_empty;
    logic [NR_SRC-1:0]               near_full;
    logic [NR_SRC-1:0]               drop;
    logic [NR_SRC*TRANS_ID_BITS-1:0] head_tid;
    logic [NR_SRC*XLEN-1:0]          head_result;
    logic [NR_SRC-1:0]               head_exv;
    logic [NR_SRC*XLEN-1:0]          head_cause;
    logic [NR_SRC*XLEN-1:0]          head_tval;

    logic [SRC_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]                grant_idx;
    logic                            grant_found;
    logic                            overflow_q, overflow_d;
    logic                            pop_any;

    // ------------------------------------------------------------------------
    // Per-source FIFOs
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NR_SRC; k++) begin : g_fifo
        logic [CNT_W-1:0]         cnt_q, cnt_d;
        logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
        logic                     push, pop, accept;
        logic [TRANS_ID_BITS-1:0] tid_mem    [DEPTH];
        logic [XLEN-1:0]          result_mem [DEPTH];
        logic                     exv_mem    [DEPTH];
        logic [XLEN-1:0]          cause_mem  [DEPTH];
        logic [XLEN-1:0]          tval_mem   [DEPTH];

        always_comb begin
            push     = src_valid_i[k] && !flush_i;
            pop      = pop_any && (grant_idx == SRC_W'(k));
            // A full FIFO still accepts when its head leaves in the same cycle.
            accept   = push && ((cnt_q != CNT_W'(DEPTH)) || pop);
            cnt_d    = cnt_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            if (flush_i) begin
                cnt_d    = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end else begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                case ({accept, pop})
                    2'b10:   cnt_d = cnt_q + CNT_W'(1);
                    2'b01:   cnt_d = cnt_q - CNT_W'(1);
                    default: cnt_d = cnt_q;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q    <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                cnt_q    <= cnt_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (accept) begin
                tid_mem[wr_ptr_q]    <= src_trans_id_i[k*TRANS_ID_BITS +: TRANS_ID_BITS];
                result_mem[wr_ptr_q] <= src_result_i[k*XLEN +: XLEN];
                exv_mem[wr_ptr_q]    <= src_ex_valid_i[k];
                cause_mem[wr_ptr_q]  <= src_ex_cause_i[k*XLEN +: XLEN];
                tval_mem[wr_ptr_q]   <= src_ex_tval_i[k*XLEN +: XLEN];
            end
        end

        assign not_empty[k] = (cnt_q != '0);
        assign near_full[k] = (cnt_q >= CNT_W'(DEPTH - 1));
        assign drop[k]      = push && (cnt_q == CNT_W'(DEPTH)) && !pop;

        assign head_tid[k*TRANS_ID_BITS +: TRANS_ID_BITS] = tid_mem[rd_ptr_q];
        assign head_result[k*XLEN +: XLEN]                = result_mem[rd_ptr_q];
        assign head_exv[k]                                = exv_mem[rd_ptr_q];
        assign head_cause[k*XLEN +: XLEN]                 = cause_mem[rd_ptr_q];
        assign head_tval[k*XLEN +: XLEN]                  = tval_mem[rd_ptr_q];
    end

    // ------------------------------------------------------------------------
    // Round-robin grant: first non-empty FIFO at or after rr_ptr, wrapping
    // ------------------------------------------------------------------------
    always_comb begin
        int               cand_int;
        logic [SRC_W-1:0] cand;
        cand_int    = 0;
        cand        = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NR_SRC; i++) begin
            cand_int = int'(rr_ptr_q) + i;
            if (cand_int >= NR_SRC) begin
                cand_int = cand_int - NR_SRC;
            end
            cand = SRC_W'(cand_int);
            if (!grant_found && not_empty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign pop_any = grant_found && wb_ready_i && !flush_i;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        overflow_d = overflow_q | (|drop);
        if (flush_i) begin
            rr_ptr_d = '0;
        end else if (pop_any) begin
            rr_ptr_d = (grant_idx == SRC_W'(NR_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output mux; payload is forced to zero when nothing is granted
    // ------------------------------------------------------------------------
    always_comb begin
        wb_trans_id_o = '0;
        wb_result_o   = '0;
        wb_ex_valid_o = 1'b0;
        wb_ex_cause_o = '0;
        wb_ex_tval_o  = '0;
        for (int k = 0; k < NR_SRC; k++) begin
            if (grant_found && (grant_idx == SRC_W'(k))) begin
                wb_trans_id_o = head_tid[k*TRANS_ID_BITS +: TRANS_ID_BITS];
                wb_result_o   = head_result[k*XLEN +: XLEN];
                wb_ex_valid_o = head_exv[k];
                wb_ex_cause_o = head_cause[k*XLEN +: XLEN];
                wb_ex_tval_o  = head_tval[k*XLEN +: XLEN];
            end
        end
    end

    assign wb_valid_o  = grant_found;
    assign wb_src_o    = grant_found ? 2'(grant_idx) : 2'b00;
    assign src_stall_o = |near_full;
    assign overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed self-checking bench for wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int NS  = 3;
    localparam int TID = 3;
    localparam int XL  = 64;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic [NS-1:0]     src_valid;
    logic [NS*TID-1:0] src_tid;
    logic [NS*XL-1:0]  src_result;
    logic [NS-1:0]     src_exv;
    logic [NS*XL-1:0]  src_cause;
    logic [NS*XL-1:0]  src_tval;
    logic              src_stall;
    logic              wb_valid;
    logic              wb_ready;
    logic [1:0]        wb_src;
    logic [TID-1:0]    wb_tid;
    logic [XL-1:0]     wb_result;
    logic              wb_exv;
    logic [XL-1:0]     wb_cause;
    logic [XL-1:0]     wb_tval;
    logic              overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .NR_SRC        (NS),
        .DEPTH         (4),
        .XLEN          (XL),
        .TRANS_ID_BITS (TID)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .src_valid_i    (src_valid),
        .src_trans_id_i (src_tid),
        .src_result_i   (src_result),
        .src_ex_valid_i (src_exv),
        .src_ex_cause_i (src_cause),
        .src_ex_tval_i  (src_tval),
        .src_stall_o    (src_stall),
        .wb_valid_o     (wb_valid),
        .wb_ready_i     (wb_ready),
        .wb_src_o       (wb_src),
        .wb_trans_id_o  (wb_tid),
        .wb_result_o    (wb_result),
        .wb_ex_valid_o  (wb_exv),
        .wb_ex_cause_o  (wb_cause),
        .wb_ex_tval_o   (wb_tval),
        .overflow_o     (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int k, input logic [TID-1:0] tid, input logic [XL-1:0] res,
                           input logic exv, input logic [XL-1:0] cause, input logic [XL-1:0] tval);
        src_valid[k]               = 1'b1;
        src_tid[k*TID +: TID]      = tid;
        src_result[k*XL +: XL]     = res;
        src_exv[k]                 = exv;
        src_cause[k*XL +: XL]      = cause;
        src_tval[k*XL +: XL]       = tval;
    endtask

    task automatic clr_src();
        src_valid = '0;
        src_exv   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i      = 1'b1;
        flush_i    = 1'b0;
        wb_ready   = 1'b0;
        src_valid  = '0;
        src_tid    = '0;
        src_result = '0;
        src_exv    = '0;
        src_cause  = '0;
        src_tval   = '0;

        // Reset state
        tick();
        tick();
        rst_i = 1'b0;
        settle();
        chk("rst_valid",    wb_valid,  0);
        chk("rst_stall",    src_stall, 0);
        chk("rst_overflow", overflow,  0);
        chk("rst_result",   wb_result, 0);
        chk("rst_src",      wb_src,    0);
        chk("rst_tid",      wb_tid,    0);

        // Single push: one-cycle latency, no bypass, payload zero when idle
        wb_ready = 1'b1;
        set_src(0, 3'd5, 64'hABCD, 1'b0, 64'h0, 64'h0);
        settle();
        chk("single_no_bypass", wb_valid, 0);
        tick();
        clr_src();
        settle();
        chk("single_valid",  wb_valid,  1);
        chk("single_src",    wb_src,    0);
        chk("single_tid",    wb_tid,    5);
        chk("single_result", wb_result, 64'hABCD);
        chk("single_exv",    wb_exv,    0);
        tick();
        settle();
        chk("single_drained", wb_valid,  0);
        chk("single_zero",    wb_result, 0);

        // Flush to bring rr_ptr back to 0
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;

        // Round-robin across all three sources
        set_src(0, 3'd1, 64'h10, 1'b0, 64'h0, 64'h0);
        set_src(1, 3'd2, 64'h20, 1'b1, 64'h2, 64'hDEAD);
        set_src(2, 3'd3, 64'h30, 1'b0, 64'h0, 64'h0);
        tick();
        clr_src();
        settle();
        chk("rr_c1_src", wb_src, 0);
        chk("rr_c1_tid", wb_tid, 1);
        tick();
        settle();
        chk("rr_c2_src",   wb_src,   1);
        chk("rr_c2_tid",   wb_tid,   2);
        chk("rr_c2_exv",   wb_exv,   1);
        chk("rr_c2_cause", wb_cause, 2);
        chk("rr_c2_tval",  wb_tval,  64'hDEAD);
        tick();
        set_src(0, 3'd4, 64'h40, 1'b0, 64'h0, 64'h0);
        set_src(2, 3'd5, 64'h50, 1'b0, 64'h0, 64'h0);
        settle();
        chk("rr_c3_src", wb_src, 2);
        chk("rr_c3_tid", wb_tid, 3);
        tick();
        clr_src();
        settle();
        chk("rr_c4_src",    wb_src,    0);
        chk("rr_c4_tid",    wb_tid,    4);
        chk("rr_c4_result", wb_result, 64'h40);
        tick();
        settle();
        chk("rr_c5_src", wb_src, 2);
        chk("rr_c5_tid", wb_tid, 5);
        tick();
        settle();
        chk("rr_empty", wb_valid, 0);

        // Backpressure on source 1
        wb_ready = 1'b0;
        set_src(1, 3'd1, 64'h101, 1'b0, 64'h0, 64'h0);
        tick();
        set_src(1, 3'd2, 64'h102, 1'b0, 64'h0, 64'h0);
        tick();
        set_src(1, 3'd3, 64'h103, 1'b0, 64'h0, 64'h0);
        settle();
        chk("bp_stall_cnt2", src_stall, 0);
        tick();
        clr_src();
        settle();
        chk("bp_stall_cnt3", src_stall, 1);
        chk("bp_valid",      wb_valid,  1);
        chk("bp_src",        wb_src,    1);
        chk("bp_tid",        wb_tid,    1);
        tick();
        settle();
        chk("bp_hold_tid",    wb_tid,    1);
        chk("bp_hold_result", wb_result, 64'h101);
        wb_ready = 1'b1;
        tick();
        settle();
        chk("bp_pop1_tid",   wb_tid,    2);
        chk("bp_pop1_stall", src_stall, 0);
        tick();
        settle();
        chk("bp_pop2_tid", wb_tid, 3);
        tick();
        settle();
        chk("bp_empty", wb_valid, 0);

        // Overflow: fifth push into a full FIFO is dropped
        wb_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_src(1, TID'(i), 64'h200 + 64'(i), 1'b0, 64'h0, 64'h0);
            if (i == 5) begin
                settle();
                chk("ovf_before", overflow, 0);
            end
            tick();
        end
        clr_src();
        settle();
        chk("ovf_set",   overflow,  1);
        chk("ovf_stall", src_stall, 1);
        tick();
        settle();
        chk("ovf_sticky", overflow, 1);
        wb_ready = 1'b1;
        settle();
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain_tid",    wb_tid,    64'(i));
            chk("ovf_drain_result", wb_result, 64'h200 + 64'(i));
            tick();
            settle();
        end
        chk("ovf_drain_empty", wb_valid, 0);
        chk("ovf_after_drain", overflow, 1);

        // Flush: discards entries and that cycle's pushes, resets rr_ptr, keeps overflow
        wb_ready = 1'b0;
        set_src(0, 3'd1, 64'h1, 1'b0, 64'h0, 64'h0);
        set_src(1, 3'd2, 64'h2, 1'b0, 64'h0, 64'h0);
        set_src(2, 3'd3, 64'h3, 1'b0, 64'h0, 64'h0);
        tick();
        clr_src();
        settle();
        chk("preflush_src", wb_src, 2);
        flush_i  = 1'b1;
        wb_ready = 1'b1;
        set_src(0, 3'd7, 64'h7, 1'b0, 64'h0, 64'h0);
        set_src(1, 3'd7, 64'h7, 1'b0, 64'h0, 64'h0);
        set_src(2, 3'd7, 64'h7, 1'b0, 64'h0, 64'h0);
        tick();
        flush_i  = 1'b0;
        wb_ready = 1'b0;
        clr_src();
        settle();
        chk("flush_valid",    wb_valid,  0);
        chk("flush_overflow", overflow,  1);
        chk("flush_stall",    src_stall, 0);
        set_src(0, 3'd4, 64'h4, 1'b0, 64'h0, 64'h0);
        set_src(1, 3'd5, 64'h5, 1'b0, 64'h0, 64'h0);
        set_src(2, 3'd6, 64'h6, 1'b0, 64'h0, 64'h0);
        tick();
        clr_src();
        settle();
        chk("flush_rr0_src", wb_src, 0);
        chk("flush_rr0_tid", wb_tid, 4);

        // Reset with entries pending clears everything including overflow
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        settle();
        chk("rst2_valid",    wb_valid,  0);
        chk("rst2_overflow", overflow,  0);
        chk("rst2_stall",    src_stall, 0);

        // Full FIFO with simultaneous push and pop
        wb_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_src(0, TID'(i), 64'h300 + 64'(i), 1'b0, 64'h0, 64'h0);
            tick();
        end
        clr_src();
        settle();
        chk("full_stall",    src_stall, 1);
        chk("full_overflow", overflow,  0);
        chk("full_head",     wb_tid,    1);
        wb_ready = 1'b1;
        set_src(0, 3'd7, 64'h307, 1'b0, 64'h0, 64'h0);
        tick();
        clr_src();
        settle();
        chk("pp_overflow", overflow,  0);
        chk("pp_stall",    src_stall, 1);
        chk("pp_tid2",     wb_tid,    2);
        tick();
        settle();
        chk("pp_tid3", wb_tid, 3);
        tick();
        settle();
        chk("pp_tid4", wb_tid, 4);
        tick();
        settle();
        chk("pp_tid7",    wb_tid,    7);
        chk("pp_result7", wb_result, 64'h307);
        tick();
        settle();
        chk("pp_empty",     wb_valid, 0);
        chk("pp_final_ovf", overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): NR_SRC, 3, result sources (0=FLU, 1=load, 2=store).
REQ-002 SHALL have parameter DEPTH, 4, entries per source FIFO (power of two, >=2).
REQ-003 SHALL have parameter XLEN, 64, result/exception data width.
REQ-004 SHALL have parameter TRANS_ID_BITS, 3, scoreboard ID width.
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk_i, in, 1, single clock.
- rst_i, in, 1, synchronous active-high reset.
- flush_i, in, 1, pipeline flush.
- src_valid_i, in, NR_SRC, per-source result valid.
- src_trans_id_i, in, NR_SRC*TRANS_ID_BITS, per-source scoreboard ID.
- src_result_i, in, NR_SRC*XLEN, per-source result.
- src_ex_valid_i, in, NR_SRC, per-source exception flag.
- src_ex_cause_i, in, NR_SRC*XLEN, per-source exception cause.
- src_ex_tval_i, in, NR_SRC*XLEN, per-source exception tval.
- src_stall_o, out, 1, upstream issue must stop.
- wb_valid_o, out, 1, writeback valid to scoreboard.
- wb_ready_i, in, 1, scoreboard accepts writeback.
- wb_src_o, out, 2, granted source index.
- wb_trans_id_o, out, TRANS_ID_BITS, granted ID.
- wb_result_o, out, XLEN, granted result.
- wb_ex_valid_o, out, 1, granted exception flag.
- wb_ex_cause_o, out, XLEN, granted cause.
- wb_ex_tval_o, out, XLEN, granted tval.
- overflow_o, out, 1, sticky FIFO overflow error.

Function
REQ-006 SHALL hold one FIFO per source of DEPTH entries {trans_id, result, ex_valid, ex_cause, ex_tval} with a per-FIFO count 0..DEPTH.
REQ-007 SHALL push the source payload into its FIFO at the clock edge ending any cycle with src_valid_i[k]=1. There is no per-source ready.
REQ-008 SHALL make a pushed entry visible at the FIFO head no earlier than the following cycle. Minimum input-to-wb_valid_o latency is 1 cycle, with no bypass.
REQ-009 SHALL drive wb_valid_o=1 combinationally whenever any FIFO is non-empty. wb_* payload fields come from the head of the granted FIFO.
REQ-010 SHALL grant round-robin: search starts at rr_ptr and takes the first non-empty FIFO in ascending index order, with wrap-around.
REQ-011 SHALL pop the granted head and set rr_ptr to (granted index + 1) mod NR_SRC only on wb_valid_o && wb_ready_i.
REQ-012 SHALL hold grant, payload and rr_ptr unchanged while wb_valid_o=1 and wb_ready_i=0.
REQ-013 SHALL, on simultaneous push and pop of the same FIFO, leave its count unchanged. This is legal even when the FIFO is full.
REQ-014 SHALL, on a push to a full FIFO without a same-cycle pop of that FIFO, drop the entry, leave the FIFO unchanged, and set overflow_o=1 until reset.
REQ-015 SHALL drive src_stall_o combinationally high when any FIFO count >= DEPTH-1.
REQ-016 SHALL wrap read/write pointers modulo DEPTH.
REQ-017 SHALL, on flush_i=1, empty all FIFOs and set rr_ptr=0 at the next edge, and ignore that cycle's src_valid_i pushes and wb_ready_i pop.
REQ-018 SHALL NOT clear overflow_o on flush.
REQ-019 SHALL drive wb_* payload outputs to 0 when wb_valid_o=0.

Reset
REQ-020 SHALL, while rst_i=1 at a clock edge, clear all counts and pointers and set rr_ptr=0, overflow_o=0.
REQ-021 SHALL, following a reset edge, hold wb_valid_o=0, src_stall_o=0 and all wb_* payload outputs=0.
REQ-022 SHALL give rst_i priority over flush_i and pushes. Reset mid-operation discards all buffered entries.

Verification
REQ-023 Single push: src_valid_i=3'b001, trans_id=5, result=0xABCD at cycle 0 -> cycle 1: wb_valid_o=1, wb_src_o=0, wb_trans_id_o=5, wb_result_o=0xABCD; with wb_ready_i=1, cycle 2: wb_valid_o=0.
REQ-024 Round-robin: all three sources push once in cycle 0, wb_ready_i=1 -> grants src 0,1,2 in cycles 1,2,3; a further src0+src2 push in cycle 3 gives grant 0 in cycle 4 (rr_ptr=0 after src 2).
REQ-025 Backpressure: wb_ready_i=0 with 3 entries in FIFO 1 -> src_stall_o=1 (count 3 >= DEPTH-1), payload stable each cycle; raising wb_ready_i pops one per cycle.
REQ-026 Overflow: 5 consecutive src1 pushes with wb_ready_i=0 -> 5th dropped, overflow_o=1 from the next cycle and sticky; the 4 accepted entries drain in order.
REQ-027 Full push+pop: FIFO 0 full, wb_ready_i=1 with grant 0, and src0 push in the same cycle -> count stays 4, overflow_o stays 0.
REQ-028 Flush/reset: entries pending in all FIFOs plus flush_i=1 -> next cycle wb_valid_o=0, rr_ptr=0, overflow_o unchanged; repeating with rst_i=1 instead also clears overflow_o.
